lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
Parametrised load/store unit that replaces the hart's combinational single-cycle dmem port with a request/grant/response handshake to variable-latency data memory. Accepts one memory op from the execute side and generates the aligned address, byte mask and lane-shifted store data. Detects misaligned accesses and memory timeouts, and returns sign/zero-extended load data with a one-cycle done pulse. Sits between the hart's ALU/writeback logic and the data memory.

Parameters:
ADDR_W, 32, address width in bits (≥3); o_mem_addr carries the same width.
TIMEOUT, 255, cycles in WAIT without i_mem_rvalid before a timeout fault; 0 disables the timeout.
STORE_ACK, 1, 1: stores wait for i_mem_rvalid; 0: stores complete on grant.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, asynchronous, active-low
i_valid  in  1  op request from pipeline
o_ready  out  1  high only in IDLE; op accepted when i_valid&&o_ready at a rising edge
i_addr  in  ADDR_W  byte address (ALU result)
i_wdata  in  32  store data (rs2), unshifted
i_is_store  in  1  1=store, 0=load
i_size  in  2  00 byte, 01 half, 10 word, 11 illegal
i_unsigned  in  1  load zero-extend (lbu/lhu)
o_done  out  1  one-cycle completion pulse
o_rdata  out  32  extended load data; valid with o_done on loads, 0 for stores/traps
o_trap  out  1  valid with o_done
o_cause  out  2  00 none, 01 misaligned/illegal size, 10 timeout
o_busy  out  1  state!=IDLE
o_mem_req  out  1  memory request
i_mem_gnt  in  1  memory accepts request this cycle
o_mem_addr  out  ADDR_W  {addr[ADDR_W-1:2],2'b00}
o_mem_ren  out  1  o_mem_req && load
o_mem_wen  out  1  o_mem_req && store
o_mem_wdata  out  32  lane-shifted store data; 0 for loads
o_mem_mask  out  4  byte-lane mask
i_mem_rvalid  in  1  response valid
i_mem_rdata  in  32  response word

Behaviour:
- States: IDLE, REQ, WAIT, RESP. Reset (async, i_rst_n=0): state IDLE; all outputs 0 except o_ready=1; captured op and timeout counter cleared; any in-flight op is dropped with no o_done.
- IDLE: on accept, register addr/wdata/size/store/unsigned. Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size=11 -> RESP with trap, cause 01, and no memory request. Otherwise -> REQ.
- REQ: o_mem_req=1 with addr/mask/wdata held stable until i_mem_gnt. On gnt: store with STORE_ACK=0 -> RESP; otherwise -> WAIT and clear the counter.
- WAIT: i_mem_rvalid is sampled only here, never in the grant cycle. On rvalid -> RESP, capturing extracted data for loads. The counter increments each cycle without rvalid; counter==TIMEOUT-1 (TIMEOUT>0) -> RESP with trap, cause 10. Memory contract: no rvalid after the timeout window.
- RESP: o_done=1 for exactly one cycle, then IDLE. o_rdata/o_trap/o_cause are held until the next accept.
- Mask: byte 0001<<off, half 0011<<off, word 1111, where off=addr[1:0].
- Store data: wdata<<(8*off).
- Load: (rdata>>(8*off)) truncated to size, then sign- or zero-extended per i_unsigned. Word loads ignore i_unsigned.
- Minimum latency with zero-wait memory: accept at edge k, REQ in k+1 (gnt), WAIT in k+2 (rvalid), o_done in k+3. Trap path: o_done in k+1.
- i_valid while not IDLE is ignored; no queuing.

Decomposition:
- Shared header lsu_defs.vh: size codes, state encoding, cause codes.
- Sub-module lsu_lane (combinational): mask generation, store shift, load extract/extend. Instantiated once.

Test Plan:
- lw addr 0x1000, gnt immediate, rvalid first WAIT cycle with 0xDEADBEEF -> o_done at k+3, o_rdata=0xDEADBEEF, mask 1111, o_mem_addr 0x1000.
- lb addr 0x2003, rdata 0x80000000 -> mask 1000, o_rdata 0xFFFFFF80; lbu same -> 0x00000080; lhu addr 0x2002, rdata 0xBEEF0000 -> 0x0000BEEF.
- sb addr 0x2001, wdata 0x000000AB, gnt held low 3 cycles -> req/addr 0x2000/mask 0010/wdata 0x0000AB00 stable across stall; STORE_ACK=0 -> o_done the cycle after gnt.
- lh addr 0x3001 -> o_done at k+1, trap=1, cause 01, o_mem_req never asserted; same for size=11.
- TIMEOUT=4, no rvalid -> o_done 4 cycles after entering WAIT, trap=1, cause 10; the next op is accepted normally.
- i_rst_n pulled low mid-WAIT -> immediate IDLE, o_mem_req=0, o_ready=1, no o_done; i_valid during busy is ignored and no second request is issued.

Source files
------------

// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and trap causes.
// Also holds the alignment check used at accept time.
package lsu_mem_ctrl_pkg;

  localparam logic [1:0] SzByte    = 2'b00;
  localparam logic [1:0] SzHalf    = 2'b01;
  localparam logic [1:0] SzWord    = 2'b10;
  localparam logic [1:0] SzIllegal = 2'b11;

  localparam logic [1:0] StIdle = 2'b00;
  localparam logic [1:0] StReq  = 2'b01;
  localparam logic [1:0] StWait = 2'b10;
  localparam logic [1:0] StResp = 2'b11;

  localparam logic [1:0] CauseNone     = 2'b00;
  localparam logic [1:0] CauseMisalign = 2'b01;
  localparam logic [1:0] CauseTimeout  = 2'b10;

  // True when the access cannot be issued: misaligned half/word or illegal size.
  function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SzByte:  bad = 1'b0;
      SzHalf:  bad = off[0];
      SzWord:  bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_lane.sv
// Byte-lane steering for the LSU: lane mask, store data shift and load extract/extend.
// Purely combinational.
module lsu_mem_ctrl_lane
  import lsu_mem_ctrl_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_mask,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [4:0]  sh_amt;
  logic [31:0] rd_sh;

  always_comb begin
    sh_amt  = {i_off, 3'b000};
    o_wdata = i_wdata << sh_amt;
    rd_sh   = i_rdata >> sh_amt;
    o_mask  = 4'b0000;
    o_rdata = 32'h0;
    case (i_size)
      SzByte: begin
        o_mask  = 4'b0001 << i_off;
        o_rdata = i_unsigned ? {24'h0, rd_sh[7:0]} : {{24{rd_sh[7]}}, rd_sh[7:0]};
      end
      SzHalf: begin
        o_mask  = 4'b0011 << i_off;
        o_rdata = i_unsigned ? {16'h0, rd_sh[15:0]} : {{16{rd_sh[15]}}, rd_sh[15:0]};
      end
      SzWord: begin
        o_mask  = 4'b1111;
        o_rdata = i_rdata;
      end
      default: begin
        o_mask  = 4'b0000;
        o_rdata = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: turns one execute-stage memory op into a req/gnt/rvalid transaction
// with alignment and timeout traps, returning extended load data with a done pulse.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned TIMEOUT   = 255,
  parameter bit          STORE_ACK = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  input  logic              i_is_store,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  output logic              o_done,
  output logic [31:0]       o_rdata,
  output logic              o_trap,
  output logic [1:0]        o_cause,
  output logic              o_busy,
  output logic              o_mem_req,
  input  logic              i_mem_gnt,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_ren,
  output logic              o_mem_wen,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_mask,
  input  logic              i_mem_rvalid,
  input  logic [31:0]       i_mem_rdata
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic              store_q, store_d;
  logic              unsigned_q, unsigned_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              trap_q, trap_d;
  logic [1:0]        cause_q, cause_d;

  logic [3:0]  lane_mask;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;
  logic        timeout_hit;

  lsu_mem_ctrl_lane u_lane (
    .i_off      (addr_q[1:0]),
    .i_size     (size_q),
    .i_unsigned (unsigned_q),
    .i_wdata    (wdata_q),
    .i_rdata    (i_mem_rdata),
    .o_mask     (lane_mask),
    .o_wdata    (lane_wdata),
    .o_rdata    (lane_rdata)
  );

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == 32'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    store_d    = store_q;
    unsigned_d = unsigned_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    trap_d     = trap_q;
    cause_d    = cause_q;
    case (state_q)
      StIdle: begin
        if (i_valid) begin
          addr_d     = i_addr;
          wdata_d    = i_wdata;
          size_d     = i_size;
          store_d    = i_is_store;
          unsigned_d = i_unsigned;
          cnt_d      = 32'h0;
          rdata_d    = 32'h0;
          trap_d     = 1'b0;
          cause_d    = CauseNone;
          if (is_bad_access(i_size, i_addr[1:0])) begin
            state_d = StResp;
            trap_d  = 1'b1;
            cause_d = CauseMisalign;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (i_mem_gnt) begin
          cnt_d   = 32'h0;
          state_d = (store_q && !STORE_ACK) ? StResp : StWait;
        end
      end
      StWait: begin
        if (i_mem_rvalid) begin
          state_d = StResp;
          if (!store_q) rdata_d = lane_rdata;
        end else if (timeout_hit) begin
          state_d = StResp;
          trap_d  = 1'b1;
          cause_d = CauseTimeout;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      size_q     <= SzByte;
      store_q    <= 1'b0;
      unsigned_q <= 1'b0;
      cnt_q      <= 32'h0;
      rdata_q    <= 32'h0;
      trap_q     <= 1'b0;
      cause_q    <= CauseNone;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      store_q    <= store_d;
      unsigned_q <= unsigned_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      trap_q     <= trap_d;
      cause_q    <= cause_d;
    end
  end

  assign o_ready     = (state_q == StIdle);
  assign o_busy      = (state_q != StIdle);
  assign o_done      = (state_q == StResp);
  assign o_rdata     = rdata_q;
  assign o_trap      = trap_q;
  assign o_cause     = cause_q;
  assign o_mem_req   = (state_q == StReq);
  assign o_mem_ren   = o_mem_req && !store_q;
  assign o_mem_wen   = o_mem_req && store_q;
  assign o_mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign o_mem_mask  = o_mem_req ? lane_mask : 4'b0000;
  assign o_mem_wdata = (o_mem_req && store_q) ? lane_wdata : 32'h0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed self-checking bench for lsu_mem_ctrl (TIMEOUT=4, stores complete on grant).
module tb_lsu_mem_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        i_is_store;
  logic [1:0]  i_size;
  logic        i_unsigned;
  logic        o_done;
  logic [31:0] o_rdata;
  logic        o_trap;
  logic [1:0]  o_cause;
  logic        o_busy;
  logic        o_mem_req;
  logic        i_mem_gnt;
  logic [31:0] o_mem_addr;
  logic        o_mem_ren;
  logic        o_mem_wen;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_mask;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 i_clk = ~i_clk;

  lsu_mem_ctrl #(
    .ADDR_W    (32),
    .TIMEOUT   (4),
    .STORE_ACK (1'b0)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .i_is_store   (i_is_store),
    .i_size       (i_size),
    .i_unsigned   (i_unsigned),
    .o_done       (o_done),
    .o_rdata      (o_rdata),
    .o_trap       (o_trap),
    .o_cause      (o_cause),
    .o_busy       (o_busy),
    .o_mem_req    (o_mem_req),
    .i_mem_gnt    (i_mem_gnt),
    .o_mem_addr   (o_mem_addr),
    .o_mem_ren    (o_mem_ren),
    .o_mem_wen    (o_mem_wen),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_mask   (o_mem_mask),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata)
  );

  // Presents one op at a falling edge; returns at the falling edge after the accept edge.
  task automatic issue(input logic [31:0] addr, input logic [1:0] size, input logic store,
                       input logic uns, input logic [31:0] wdata);
    i_valid = 1'b1; i_addr = addr; i_size = size; i_is_store = store;
    i_unsigned = uns; i_wdata = wdata;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_valid = 1'b0; i_addr = '0; i_wdata = '0; i_is_store = 1'b0;
    i_size = 2'b00; i_unsigned = 1'b0; i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;
    i_mem_rdata = '0;
    @(negedge i_clk);
    @(negedge i_clk);
    tests_run++;
    if ({o_ready, o_busy, o_done, o_trap, o_mem_req, o_mem_ren, o_mem_wen} !== 7'b1000000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b expected 1000000",
               {o_ready, o_busy, o_done, o_trap, o_mem_req, o_mem_ren, o_mem_wen});
    end
    tests_run++;
    if ({o_rdata, o_cause, o_mem_addr, o_mem_wdata, o_mem_mask} !== 102'h0) begin
      tests_failed++;
      $display("FAIL reset_data: rdata %h cause %b addr %h wdata %h mask %b, expected all 0",
               o_rdata, o_cause, o_mem_addr, o_mem_wdata, o_mem_mask);
    end
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_lw();
    i_mem_gnt = 1'b1;
    issue(32'h1000, 2'b10, 1'b0, 1'b0, 32'h0);
    tests_run++;
    if ({o_mem_req, o_mem_ren, o_mem_wen, o_done} !== 4'b1100 || o_mem_addr !== 32'h1000 ||
        o_mem_mask !== 4'b1111 || o_mem_wdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL lw_req: req/ren/wen/done %b addr %h mask %b wdata %h, expected 1100 1000 1111 0",
               {o_mem_req, o_mem_ren, o_mem_wen, o_done}, o_mem_addr, o_mem_mask, o_mem_wdata);
    end
    @(negedge i_clk);
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'hDEADBEEF;
    tests_run++;
    if (o_mem_req !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL lw_wait: req %b done %b busy %b, expected 0 0 1", o_mem_req, o_done, o_busy);
    end
    @(negedge i_clk);
    i_mem_rvalid = 1'b0;
    tests_run++;
    if (o_done !== 1'b1 || o_rdata !== 32'hDEADBEEF || o_trap !== 1'b0 || o_cause !== 2'b00) begin
      tests_failed++;
      $display("FAIL lw_done: done %b rdata %h trap %b cause %b, expected 1 deadbeef 0 00",
               o_done, o_rdata, o_trap, o_cause);
    end
    @(negedge i_clk);
    tests_run++;
    if (o_done !== 1'b0 || o_ready !== 1'b1 || o_rdata !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL lw_hold: done %b ready %b rdata %h, expected 0 1 deadbeef",
               o_done, o_ready, o_rdata);
    end
  endtask

  task automatic test_load_ext();
    logic [31:0] v_addr [5] = '{32'h2003, 32'h2003, 32'h2002, 32'h2002, 32'h2001};
    logic [1:0]  v_size [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
    logic        v_uns  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] v_rd   [5] = '{32'h80000000, 32'h80000000, 32'hBEEF0000, 32'hBEEF0000,
                                32'h00007F00};
    logic [3:0]  v_mask [5] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b0010};
    logic [31:0] v_exp  [5] = '{32'hFFFFFF80, 32'h00000080, 32'h0000BEEF, 32'hFFFFBEEF,
                                32'h0000007F};
    for (int i = 0; i < 5; i++) begin
      i_mem_gnt = 1'b1;
      issue(v_addr[i], v_size[i], 1'b0, v_uns[i], 32'hFFFFFFFF);
      tests_run++;
      if (o_mem_mask !== v_mask[i] || o_mem_addr !== 32'h2000 || o_mem_wdata !== 32'h0) begin
        tests_failed++;
        $display("FAIL load%0d_req: mask %b addr %h wdata %h, expected %b 00002000 0",
                 i, o_mem_mask, o_mem_addr, o_mem_wdata, v_mask[i]);
      end
      @(negedge i_clk);
      i_mem_gnt = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = v_rd[i];
      @(negedge i_clk);
      i_mem_rvalid = 1'b0;
      tests_run++;
      if (o_done !== 1'b1 || o_rdata !== v_exp[i]) begin
        tests_failed++;
        $display("FAIL load%0d_data: done %b rdata %h, expected 1 %h", i, o_done, o_rdata, v_exp[i]);
      end
      @(negedge i_clk);
    end
  endtask

  task automatic test_store_stall();
    i_mem_gnt = 1'b0;
    issue(32'h2001, 2'b00, 1'b1, 1'b0, 32'h000000AB);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if ({o_mem_req, o_mem_wen, o_mem_ren, o_done} !== 4'b1100 || o_mem_addr !== 32'h2000 ||
          o_mem_mask !== 4'b0010 || o_mem_wdata !== 32'h0000AB00) begin
        tests_failed++;
        $display("FAIL sb_stall%0d: req/wen/ren/done %b addr %h mask %b wdata %h",
                 i, {o_mem_req, o_mem_wen, o_mem_ren, o_done}, o_mem_addr, o_mem_mask, o_mem_wdata);
      end
      @(negedge i_clk);
    end
    i_mem_gnt = 1'b1;
    @(negedge i_clk);
    i_mem_gnt = 1'b0;
    tests_run++;
    if (o_done !== 1'b1 || o_trap !== 1'b0 || o_rdata !== 32'h0 || o_mem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL sb_done: done %b trap %b rdata %h req %b, expected 1 0 0 0",
               o_done, o_trap, o_rdata, o_mem_req);
    end
    @(negedge i_clk);
  endtask

  task automatic test_misaligned();
    logic [31:0] v_addr [2] = '{32'h3001, 32'h3000};
    logic [1:0]  v_size [2] = '{2'b01, 2'b11};
    i_mem_gnt = 1'b1;
    for (int i = 0; i < 2; i++) begin
      issue(v_addr[i], v_size[i], 1'b0, 1'b0, 32'h0);
      tests_run++;
      if (o_done !== 1'b1 || o_trap !== 1'b1 || o_cause !== 2'b01 || o_mem_req !== 1'b0 ||
          o_rdata !== 32'h0) begin
        tests_failed++;
        $display("FAIL trap%0d_done: done %b trap %b cause %b req %b rdata %h, expected 1 1 01 0 0",
                 i, o_done, o_trap, o_cause, o_mem_req, o_rdata);
      end
      @(negedge i_clk);
      tests_run++;
      if (o_done !== 1'b0 || o_ready !== 1'b1 || o_mem_req !== 1'b0 || o_trap !== 1'b1) begin
        tests_failed++;
        $display("FAIL trap%0d_after: done %b ready %b req %b trap %b, expected 0 1 0 1",
                 i, o_done, o_ready, o_mem_req, o_trap);
      end
    end
    i_mem_gnt = 1'b0;
  endtask

  task automatic test_timeout();
    i_mem_gnt = 1'b1;
    issue(32'h4000, 2'b10, 1'b0, 1'b0, 32'h0);
    @(negedge i_clk);
    i_mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      tests_run++;
      if (o_done !== 1'b0 || o_busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL timeout_wait%0d: done %b busy %b, expected 0 1", i, o_done, o_busy);
      end
    end
    @(negedge i_clk);
    tests_run++;
    if (o_done !== 1'b1 || o_trap !== 1'b1 || o_cause !== 2'b10) begin
      tests_failed++;
      $display("FAIL timeout_done: done %b trap %b cause %b, expected 1 1 10",
               o_done, o_trap, o_cause);
    end
    @(negedge i_clk);
    i_mem_gnt = 1'b1;
    issue(32'h1004, 2'b10, 1'b0, 1'b0, 32'h0);
    @(negedge i_clk);
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h12345678;
    @(negedge i_clk);
    i_mem_rvalid = 1'b0;
    tests_run++;
    if (o_done !== 1'b1 || o_rdata !== 32'h12345678 || o_trap !== 1'b0 || o_cause !== 2'b00) begin
      tests_failed++;
      $display("FAIL after_timeout: done %b rdata %h trap %b cause %b, expected 1 12345678 0 00",
               o_done, o_rdata, o_trap, o_cause);
    end
    @(negedge i_clk);
  endtask

  task automatic test_busy_and_reset();
    i_mem_gnt = 1'b1;
    issue(32'h5000, 2'b10, 1'b0, 1'b0, 32'h0);
    @(negedge i_clk);
    i_mem_gnt = 1'b0;
    i_valid = 1'b1; i_addr = 32'h6000;
    for (int i = 0; i < 2; i++) begin
      @(negedge i_clk);
      tests_run++;
      if (o_ready !== 1'b0 || o_mem_req !== 1'b0 || o_done !== 1'b0) begin
        tests_failed++;
        $display("FAIL busy_ignore%0d: ready %b req %b done %b, expected 0 0 0",
                 i, o_ready, o_mem_req, o_done);
      end
    end
    i_rst_n = 1'b0;
    #1;
    tests_run++;
    if (o_ready !== 1'b1 || o_mem_req !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: ready %b req %b busy %b done %b, expected 1 0 0 0",
               o_ready, o_mem_req, o_busy, o_done);
    end
    i_valid = 1'b0;
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'hCAFEF00D;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    i_mem_rvalid = 1'b0;
    tests_run++;
    if (o_done !== 1'b0 || o_ready !== 1'b1 || o_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_no_done: done %b ready %b rdata %h, expected 0 1 0",
               o_done, o_ready, o_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_ext();
    test_store_stall();
    test_misaligned();
    test_timeout();
    test_busy_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
